// File: rtl/conv_seq_ctrl.sv
// Raster-order sequencer for the conv MAC datapath: MAC burst per pixel, then write-back.
// Optional abort input enabled by defining CONV_SEQ_CTRL_ABORT_EN.
module conv_seq_ctrl #(
  parameter int OUT_W      = 14,
  parameter int OUT_H      = 14,
  parameter int MAC_CYCLES = 8,
  parameter int TAP_W      = 3,
  parameter int COL_W      = 4,
  parameter int ROW_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef CONV_SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             mac_en,
  output logic             mac_clr,
  output logic [TAP_W-1:0] tap_idx,
  output logic [COL_W-1:0] out_col,
  output logic [ROW_W-1:0] out_row,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(MAC_CYCLES - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

  state_t state;
  logic   kill;

`ifdef CONV_SEQ_CTRL_ABORT_EN
  assign kill = abort && (state != IDLE);
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      tap_idx   <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
    end else if (kill) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      tap_idx   <= '0;
      out_col   <= '0;
      out_row   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= MAC;
            busy    <= 1'b1;
            mac_en  <= 1'b1;
            mac_clr <= 1'b1;
            tap_idx <= '0;
            out_col <= '0;
            out_row <= '0;
          end
        end
        MAC: begin
          mac_clr <= 1'b0;
          if (tap_idx == TAP_LAST) begin
            state     <= WB;
            mac_en    <= 1'b0;
            tap_idx   <= '0;
            out_valid <= 1'b1;
          end else begin
            tap_idx <= tap_idx + TAP_W'(1);
          end
        end
        WB: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_col == COL_LAST && out_row == ROW_LAST) begin
              state   <= DONE;
              done    <= 1'b1;
              out_col <= '0;
              out_row <= '0;
            end else begin
              // next pixel: raster advance, accumulator cleared on tap 0
              state   <= MAC;
              mac_en  <= 1'b1;
              mac_clr <= 1'b1;
              if (out_col == COL_LAST) begin
                out_col <= '0;
                out_row <= out_row + ROW_W'(1);
              end else begin
                out_col <= out_col + COL_W'(1);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: two instances (2x2x8 and 3x1x1).
// Reference model tracks pixel order, burst length and frame latency.
module tb_conv_seq_ctrl;

  localparam int NI = 2;
  localparam int TW = 3;
  localparam int CW = 4;
  localparam int RW = 4;
  localparam int PW [NI] = '{2, 3};
  localparam int PH [NI] = '{2, 1};
  localparam int PM [NI] = '{8, 1};

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic rchk;
`ifdef CONV_SEQ_CTRL_ABORT_EN
  logic abort;
`endif
  logic [NI-1:0] rdy;
  logic [NI-1:0] busy;
  logic [NI-1:0] done;
  logic [NI-1:0] mac_en;
  logic [NI-1:0] mac_clr;
  logic [NI-1:0] ovalid;
  logic [TW-1:0] tap [NI];
  logic [CW-1:0] col [NI];
  logic [RW-1:0] row [NI];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int tmo        = 0;
  int tmo_seen   = 0;
  bit rseen      = 1'b0;

  int q [NI][$];
  int mcnt [NI];
  int stalls [NI];
  int scyc [NI];
  bit act [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_seq_ctrl #(
    .OUT_W(2), .OUT_H(2), .MAC_CYCLES(8),
    .TAP_W(TW), .COL_W(CW), .ROW_W(RW)
  ) u0 (
    .clk(clk), .reset(reset), .start(start),
`ifdef CONV_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy[0]), .done(done[0]),
    .mac_en(mac_en[0]), .mac_clr(mac_clr[0]),
    .tap_idx(tap[0]), .out_col(col[0]), .out_row(row[0]),
    .out_valid(ovalid[0]), .out_ready(rdy[0])
  );

  conv_seq_ctrl #(
    .OUT_W(3), .OUT_H(1), .MAC_CYCLES(1),
    .TAP_W(TW), .COL_W(CW), .ROW_W(RW)
  ) u1 (
    .clk(clk), .reset(reset), .start(start),
`ifdef CONV_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy[1]), .done(done[1]),
    .mac_en(mac_en[1]), .mac_clr(mac_clr[1]),
    .tap_idx(tap[1]), .out_col(col[1]), .out_row(row[1]),
    .out_valid(ovalid[1]), .out_ready(rdy[1])
  );

  task automatic chk(input string nm, input int k,
                     input int got, input int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s u%0d @cyc %0d: got %0d want %0d",
               nm, k, cyc, got, want);
    end
  endtask

  function automatic int pack_all(input int k);
    return int'({busy[k], done[k], mac_en[k], mac_clr[k],
                 ovalid[k], tap[k], col[k], row[k]});
  endfunction

  task automatic mon(input int k);
    bit was_act;
    int want;
    if (reset) begin
      q[k].delete();
      act[k]    = 1'b0;
      mcnt[k]   = 0;
      stalls[k] = 0;
      return;
    end
    was_act = act[k];
    if (!act[k]) begin
      chk("idle", k, pack_all(k), 0);
    end else begin
      chk("active", k, int'(mac_en[k] | ovalid[k] | done[k]), 1);
      if (done[k]) begin
        chk("done_lat", k, cyc - scyc[k],
            PW[k] * PH[k] * (PM[k] + 1) + 1 + stalls[k]);
        chk("done_st", k,
            int'({busy[k], mac_en[k], ovalid[k],
                  q[k].size() == 0, mcnt[k] == 0}), 5'b10011);
        act[k] = 1'b0;
      end else if (mac_en[k]) begin
        chk("tap", k, int'(tap[k]), mcnt[k]);
        chk("mac_flags", k,
            int'({q[k].size() != 0, ovalid[k], busy[k], mac_clr[k]}),
            int'({1'b1, 1'b0, 1'b1, mcnt[k] == 0}));
        mcnt[k]++;
      end else if (ovalid[k]) begin
        chk("burst_len", k, mcnt[k], PM[k]);
        want = (q[k].size() != 0) ? q[k][0] : -1;
        chk("wb_pix", k, int'(row[k]) * 256 + int'(col[k]), want);
        chk("wb_flags", k, int'({busy[k], mac_en[k], done[k]}), 3'b100);
        if (rdy[k]) begin
          if (q[k].size() != 0) void'(q[k].pop_front());
          mcnt[k] = 0;
        end else begin
          stalls[k]++;
        end
      end
`ifdef CONV_SEQ_CTRL_ABORT_EN
      if (abort) begin
        q[k].delete();
        act[k] = 1'b0;
        mcnt[k] = 0;
      end
`endif
    end
    // start presented now is sampled at the coming edge only if idle
    if (!was_act && start) begin
      act[k]    = 1'b1;
      scyc[k]   = cyc;
      stalls[k] = 0;
      mcnt[k]   = 0;
      q[k].delete();
      for (int r = 0; r < PH[k]; r++)
        for (int c = 0; c < PW[k]; c++)
          q[k].push_back(r * 256 + c);
    end
  endtask

  always @(negedge clk or posedge rchk) begin
    if (rchk && !rseen) begin
      rseen = 1'b1;
      for (int k = 0; k < NI; k++) chk("async_rst", k, pack_all(k), 0);
    end else if (!clk) begin
      if (!rchk) rseen = 1'b0;
      if (tmo != tmo_seen) begin
        compared++;
        mismatched++;
        $display("FAIL timeout: got %0d expired waits want 0", tmo);
        tmo_seen = tmo;
      end
      for (int k = 0; k < NI; k++) mon(k);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy != '0 && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) tmo++;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    rchk  = 1'b0;
    rdy   = 2'b11;
`ifdef CONV_SEQ_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    step();

    // basic frame
    pulse_start();
    wait_idle(200);
    step();

    // back-pressure at the first write-back
    pulse_start();
    n = 0;
    while (!ovalid[0] && n < 100) begin step(); n++; end
    if (n >= 100) tmo++;
    rdy[0] = 1'b0;
    repeat (5) step();
    rdy[0] = 1'b1;
    wait_idle(200);
    step();

    // start while busy and during the done cycle
    pulse_start();
    repeat (5) step();
    pulse_start();
    n = 0;
    while (!done[0] && n < 100) begin step(); n++; end
    if (n >= 100) tmo++;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(200);
    step();

    // random ready and start traffic
    for (int i = 0; i < 600; i++) begin
      rdy   = 2'($urandom);
      start = ($urandom_range(0, 11) == 0);
      step();
    end
    start = 1'b0;
    rdy   = 2'b11;
    wait_idle(300);
    step();

    // reset during tap 4 of pixel (0,1)
    pulse_start();
    n = 0;
    while (!(mac_en[0] && tap[0] == 3'd4 && col[0] == 4'd1 &&
             row[0] == 4'd0) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) tmo++;
    #2 reset = 1'b1;
    #1 rchk = 1'b1;
    step();
    step();
    reset = 1'b0;
    rchk  = 1'b0;
    step();
    pulse_start();
    wait_idle(200);
    step();

`ifdef CONV_SEQ_CTRL_ABORT_EN
    pulse_start();
    n = 0;
    while (!ovalid[0] && n < 100) begin step(); n++; end
    if (n >= 100) tmo++;
    rdy[0] = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    rdy   = 2'b11;
    wait_idle(200);
    step();
    pulse_start();
    wait_idle(200);
    step();
`endif

    repeat (3) step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
